// File: rtl/registrador_if_id_if.sv
// Handshake and data bundle between fetch, the IF/ID register and decode.
interface registrador_if_id_if #(
    parameter int unsigned LARGURA = 32
) ();

    logic [LARGURA-1:0] entradaPC4;
    logic [LARGURA-1:0] entradaInstrucao;
    logic               valido_entrada;
    logic               pronto_saida;
    logic               flush;
    logic               valido_saida;
    logic               pronto_entrada;
    logic [LARGURA-1:0] saidaPC4;
    logic [LARGURA-1:0] saidaInstrucao;
    logic [7:0]         contador_descartes;

    // Seen from the pipeline register itself.
    modport slave (
        input  entradaPC4,
        input  entradaInstrucao,
        input  valido_entrada,
        input  flush,
        input  pronto_entrada,
        output pronto_saida,
        output valido_saida,
        output saidaPC4,
        output saidaInstrucao,
        output contador_descartes
    );

    // Seen from the surrounding fetch/decode logic.
    modport master (
        output entradaPC4,
        output entradaInstrucao,
        output valido_entrada,
        output flush,
        output pronto_entrada,
        input  pronto_saida,
        input  valido_saida,
        input  saidaPC4,
        input  saidaInstrucao,
        input  contador_descartes
    );

endinterface

// File: rtl/registrador_if_id.sv
// IF/ID pipeline register: two-entry (head + skid) buffer with valid/ready handshake,
// branch flush and a saturating count of discarded instructions.
module registrador_if_id #(
    parameter int unsigned         LARGURA = 32,
    parameter logic [LARGURA-1:0]  NOP     = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    registrador_if_id_if.slave   bus
);

    logic [1:0]         ocupacao_q, ocupacao_d;
    logic [LARGURA-1:0] head_pc4_q, head_pc4_d;
    logic [LARGURA-1:0] head_instr_q, head_instr_d;
    logic [LARGURA-1:0] skid_pc4_q, skid_pc4_d;
    logic [LARGURA-1:0] skid_instr_q, skid_instr_d;
    logic [7:0]         descartes_q, descartes_d;

    logic       aceita;
    logic       retira;
    logic [1:0] pendentes;
    logic [8:0] soma;

    // Ready/valid are decoded from registered occupancy only: no comb path from decode to fetch.
    assign bus.pronto_saida       = (ocupacao_q != 2'd2);
    assign bus.valido_saida       = (ocupacao_q != 2'd0);
    assign bus.saidaPC4           = head_pc4_q;
    assign bus.saidaInstrucao     = head_instr_q;
    assign bus.contador_descartes = descartes_q;

    assign aceita = bus.valido_entrada & bus.pronto_saida;
    assign retira = bus.valido_saida & bus.pronto_entrada;

    // Next-state: flush dominates, otherwise FIFO movement between input, head and skid.
    always_comb begin
        ocupacao_d   = ocupacao_q;
        head_pc4_d   = head_pc4_q;
        head_instr_d = head_instr_q;
        skid_pc4_d   = skid_pc4_q;
        skid_instr_d = skid_instr_q;
        descartes_d  = descartes_q;

        // Entries lost to a flush: whatever decode does not take this cycle, plus an offered beat.
        pendentes = ocupacao_q - {1'b0, retira};
        soma      = {1'b0, descartes_q} + {7'd0, pendentes} + {8'd0, aceita};

        if (bus.flush) begin
            ocupacao_d   = 2'd0;
            head_pc4_d   = '0;
            head_instr_d = NOP;
            skid_pc4_d   = '0;
            skid_instr_d = NOP;
            descartes_d  = soma[8] ? 8'hFF : soma[7:0];
        end else begin
            case (ocupacao_q)
                2'd0: begin
                    if (aceita) begin
                        ocupacao_d   = 2'd1;
                        head_pc4_d   = bus.entradaPC4;
                        head_instr_d = bus.entradaInstrucao;
                    end
                end
                2'd1: begin
                    if (aceita && retira) begin
                        head_pc4_d   = bus.entradaPC4;
                        head_instr_d = bus.entradaInstrucao;
                    end else if (aceita) begin
                        ocupacao_d   = 2'd2;
                        skid_pc4_d   = bus.entradaPC4;
                        skid_instr_d = bus.entradaInstrucao;
                    end else if (retira) begin
                        // Empty head must read as a bubble on the outputs.
                        ocupacao_d   = 2'd0;
                        head_pc4_d   = '0;
                        head_instr_d = NOP;
                    end
                end
                2'd2: begin
                    if (retira) begin
                        ocupacao_d   = 2'd1;
                        head_pc4_d   = skid_pc4_q;
                        head_instr_d = skid_instr_q;
                        skid_pc4_d   = '0;
                        skid_instr_d = NOP;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to empty.
                    ocupacao_d   = 2'd0;
                    head_pc4_d   = '0;
                    head_instr_d = NOP;
                    skid_pc4_d   = '0;
                    skid_instr_d = NOP;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ocupacao_q   <= 2'd0;
            head_pc4_q   <= '0;
            head_instr_q <= NOP;
            skid_pc4_q   <= '0;
            skid_instr_q <= NOP;
            descartes_q  <= 8'd0;
        end else begin
            ocupacao_q   <= ocupacao_d;
            head_pc4_q   <= head_pc4_d;
            head_instr_q <= head_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_instr_q <= skid_instr_d;
            descartes_q  <= descartes_d;
        end
    end

endmodule

// File: tb/tb_registrador_if_id.sv
// Directed self-checking bench for the IF/ID pipeline register.
module tb_registrador_if_id;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    registrador_if_id_if #(.LARGURA(32)) bus ();

    registrador_if_id #(
        .LARGURA (32),
        .NOP     (32'h00000000)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc4, input logic [31:0] instr);
        bus.valido_entrada   = 1'b1;
        bus.entradaPC4       = pc4;
        bus.entradaInstrucao = instr;
    endtask

    task automatic test_reset();
        bus.valido_entrada   = 1'b0;
        bus.entradaPC4       = '0;
        bus.entradaInstrucao = '0;
        bus.flush            = 1'b0;
        bus.pronto_entrada   = 1'b0;
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if (bus.valido_saida !== 1'b0) begin
            n_err++; $display("FAIL reset_valido: got %b want 0", bus.valido_saida);
        end
        n_cmp++;
        if (bus.pronto_saida !== 1'b1) begin
            n_err++; $display("FAIL reset_pronto: got %b want 1", bus.pronto_saida);
        end
        n_cmp++;
        if (bus.saidaPC4 !== 32'h0 || bus.saidaInstrucao !== 32'h0) begin
            n_err++; $display("FAIL reset_data: got pc4=%h instr=%h want 0/0",
                              bus.saidaPC4, bus.saidaInstrucao);
        end
        n_cmp++;
        if (bus.contador_descartes !== 8'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.contador_descartes);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
    endtask

    // Four beats at full rate: each is on the outputs one edge after it is offered.
    task automatic test_stream();
        logic [31:0] pcs [4];
        logic [31:0] ins [4];
        pcs = '{32'h4, 32'h8, 32'hC, 32'h10};
        ins = '{32'h20090001, 32'h20090002, 32'h20090003, 32'h20090004};
        bus.pronto_entrada = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(pcs[i], ins[i]);
            step();
            n_cmp++;
            if (bus.valido_saida !== 1'b1 || bus.saidaPC4 !== pcs[i] ||
                bus.saidaInstrucao !== ins[i] || bus.pronto_saida !== 1'b1) begin
                n_err++;
                $display("FAIL stream_beat%0d: got v=%b r=%b pc4=%h instr=%h want 1 1 %h %h",
                         i, bus.valido_saida, bus.pronto_saida, bus.saidaPC4,
                         bus.saidaInstrucao, pcs[i], ins[i]);
            end
        end
        bus.valido_entrada = 1'b0;
        step();
        n_cmp++;
        if (bus.valido_saida !== 1'b0 || bus.saidaInstrucao !== 32'h0) begin
            n_err++; $display("FAIL stream_drain: got v=%b instr=%h want 0 00000000",
                              bus.valido_saida, bus.saidaInstrucao);
        end
    endtask

    task automatic test_backpressure();
        bus.pronto_entrada = 1'b0;
        offer(32'h100, 32'hA1);
        step();
        offer(32'h104, 32'hA2);
        step();
        n_cmp++;
        if (bus.pronto_saida !== 1'b0 || bus.valido_saida !== 1'b1 || bus.saidaPC4 !== 32'h100) begin
            n_err++; $display("FAIL bp_full: got r=%b v=%b pc4=%h want 0 1 00000100",
                              bus.pronto_saida, bus.valido_saida, bus.saidaPC4);
        end
        offer(32'h108, 32'hA3);
        step();
        n_cmp++;
        if (bus.pronto_saida !== 1'b0 || bus.saidaInstrucao !== 32'hA1) begin
            n_err++; $display("FAIL bp_hold: got r=%b instr=%h want 0 000000a1",
                              bus.pronto_saida, bus.saidaInstrucao);
        end
        bus.pronto_entrada = 1'b1;
        step();
        n_cmp++;
        if (bus.saidaPC4 !== 32'h104 || bus.saidaInstrucao !== 32'hA2 ||
            bus.pronto_saida !== 1'b1) begin
            n_err++; $display("FAIL bp_beat2: got pc4=%h instr=%h r=%b want 00000104 000000a2 1",
                              bus.saidaPC4, bus.saidaInstrucao, bus.pronto_saida);
        end
        step();
        n_cmp++;
        if (bus.saidaPC4 !== 32'h108 || bus.saidaInstrucao !== 32'hA3 || bus.valido_saida !== 1'b1) begin
            n_err++; $display("FAIL bp_beat3: got pc4=%h instr=%h v=%b want 00000108 000000a3 1",
                              bus.saidaPC4, bus.saidaInstrucao, bus.valido_saida);
        end
        bus.valido_entrada = 1'b0;
        step();
        n_cmp++;
        if (bus.valido_saida !== 1'b0) begin
            n_err++; $display("FAIL bp_drain: got v=%b want 0", bus.valido_saida);
        end
    endtask

    // Flush while empty with a beat offered: the beat is dropped and counted.
    task automatic test_flush_offered();
        bus.pronto_entrada = 1'b0;
        offer(32'h200, 32'hB1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.valido_entrada = 1'b0;
        n_cmp++;
        if (bus.valido_saida !== 1'b0 || bus.contador_descartes !== 8'd1) begin
            n_err++; $display("FAIL flush_offered: got v=%b cnt=%0d want 0 1",
                              bus.valido_saida, bus.contador_descartes);
        end
    endtask

    // Flush with both entries held: two entries lost; the offered beat is not accepted.
    task automatic test_flush_full();
        bus.pronto_entrada = 1'b0;
        offer(32'h300, 32'hC1);
        step();
        offer(32'h304, 32'hC2);
        step();
        offer(32'h308, 32'hC3);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.valido_entrada = 1'b0;
        n_cmp++;
        if (bus.valido_saida !== 1'b0 || bus.pronto_saida !== 1'b1) begin
            n_err++; $display("FAIL flush_full_state: got v=%b r=%b want 0 1",
                              bus.valido_saida, bus.pronto_saida);
        end
        n_cmp++;
        if (bus.saidaInstrucao !== 32'h0 || bus.saidaPC4 !== 32'h0) begin
            n_err++; $display("FAIL flush_full_data: got instr=%h pc4=%h want 0 0",
                              bus.saidaInstrucao, bus.saidaPC4);
        end
        n_cmp++;
        if (bus.contador_descartes !== 8'd3) begin
            n_err++; $display("FAIL flush_full_cnt: got %0d want 3", bus.contador_descartes);
        end
        // Skid was cleared: a fresh beat must come out, not the old C2.
        bus.pronto_entrada = 1'b1;
        offer(32'h30C, 32'hC4);
        step();
        bus.valido_entrada = 1'b0;
        n_cmp++;
        if (bus.saidaInstrucao !== 32'hC4) begin
            n_err++; $display("FAIL flush_full_next: got instr=%h want 000000c4", bus.saidaInstrucao);
        end
        step();
    endtask

    // Flush in the same cycle decode takes the only entry: nothing is counted.
    task automatic test_flush_retira();
        bus.pronto_entrada = 1'b0;
        offer(32'h400, 32'hD1);
        step();
        bus.valido_entrada = 1'b0;
        bus.pronto_entrada = 1'b1;
        bus.flush = 1'b1;
        #2;
        n_cmp++;
        if (bus.valido_saida !== 1'b1 || bus.saidaInstrucao !== 32'hD1) begin
            n_err++; $display("FAIL flush_retira_head: got v=%b instr=%h want 1 000000d1",
                              bus.valido_saida, bus.saidaInstrucao);
        end
        step();
        bus.flush = 1'b0;
        n_cmp++;
        if (bus.contador_descartes !== 8'd3 || bus.valido_saida !== 1'b0) begin
            n_err++; $display("FAIL flush_retira: got cnt=%0d v=%b want 3 0",
                              bus.contador_descartes, bus.valido_saida);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        exp_cnt = 3;
        bus.pronto_entrada = 1'b0;
        for (int i = 0; i < 260; i++) begin
            offer(32'h500 + i, 32'hE0 + i);
            step();
            bus.valido_entrada = 1'b0;
            bus.flush = 1'b1;
            step();
            bus.flush = 1'b0;
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            n_cmp++;
            if (bus.contador_descartes !== exp_cnt[7:0]) begin
                n_err++; $display("FAIL sat_iter%0d: got %0d want %0d",
                                  i, bus.contador_descartes, exp_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.pronto_entrada = 1'b0;
        offer(32'h600, 32'hF1);
        step();
        offer(32'h604, 32'hF2);
        step();
        bus.valido_entrada = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.valido_saida !== 1'b0 || bus.pronto_saida !== 1'b1 || bus.saidaPC4 !== 32'h0 ||
            bus.saidaInstrucao !== 32'h0 || bus.contador_descartes !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b r=%b pc4=%h instr=%h cnt=%0d want 0 1 0 0 0",
                     bus.valido_saida, bus.pronto_saida, bus.saidaPC4, bus.saidaInstrucao,
                     bus.contador_descartes);
        end
        #1;
        reset_n = 1'b1;
        offer(32'h700, 32'h77);
        step();
        bus.valido_entrada = 1'b0;
        n_cmp++;
        if (bus.valido_saida !== 1'b1 || bus.saidaPC4 !== 32'h700 || bus.saidaInstrucao !== 32'h77) begin
            n_err++; $display("FAIL after_reset: got v=%b pc4=%h instr=%h want 1 00000700 00000077",
                              bus.valido_saida, bus.saidaPC4, bus.saidaInstrucao);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_offered();
        test_flush_full();
        test_flush_retira();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
